// File: rtl/load_value_predictor_pkg.sv
// Shared types for the last-value load predictor: FSM states, table entry layout, widths.
// LVP_STATS_EN with SIMULATION also provides the stats_event trace hook.
package load_value_predictor_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int LVP_INDEX_BITS  = 6;
    localparam int LVP_CONF_BITS   = 2;
    localparam int LVP_CONF_THRESH = 2;

    function automatic int lvp_tag_w(input int index_bits);
        return DATA_WIDTH - index_bits - 2;
    endfunction

    localparam int LVP_TAG_W = lvp_tag_w(LVP_INDEX_BITS);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        SPEC,
        TRAIN,
        RECOVER
    } lvp_state_e;

    typedef struct packed {
        logic                     valid;
        logic [LVP_TAG_W-1:0]     tag;
        logic [DATA_WIDTH-1:0]    value;
        logic [LVP_CONF_BITS-1:0] conf;
    } lvp_entry_t;

`ifdef LVP_STATS_EN
`ifdef SIMULATION
    // Trace hook for the simulation environment; intentionally side-effect free here.
    function automatic void stats_event(input string name);
        string r_last;
        r_last = name;
    endfunction
`endif
`endif

endpackage

// File: rtl/load_value_predictor_if.sv
// Hazard-control <-> load value predictor bus. master = hazard controller, slave = predictor.
interface load_value_predictor_if;
    import load_value_predictor_pkg::*;

    logic                  vp_en;
    logic [DATA_WIDTH-1:0] pc;
    logic                  mem_valid;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  recovery_done;
    logic [DATA_WIDTH-1:0] pred_value;
    logic                  pred_valid;
    logic                  vp_lock;
    logic                  done;
    logic                  recover;
    logic [DATA_WIDTH-1:0] last_pc;

    modport master (
        output vp_en, pc, mem_valid, mem_data, recovery_done,
        input  pred_value, pred_valid, vp_lock, done, recover, last_pc
    );

    modport slave (
        input  vp_en, pc, mem_valid, mem_data, recovery_done,
        output pred_value, pred_valid, vp_lock, done, recover, last_pc
    );

endinterface

// File: rtl/load_value_predictor_table.sv
// Direct-mapped predictor table: 1R1W, registered read, valid bits cleared by async reset.
module load_value_predictor_table
    import load_value_predictor_pkg::*;
#(
    parameter int INDEX_BITS = LVP_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rd_en,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    output lvp_entry_t            o_rd_entry,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  lvp_entry_t            i_wr_entry
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [DEPTH-1:0]         r_valid;
    logic [LVP_TAG_W-1:0]     r_tag   [DEPTH];
    logic [DATA_WIDTH-1:0]    r_value [DEPTH];
    logic [LVP_CONF_BITS-1:0] r_conf  [DEPTH];

    logic                     r_rd_valid;
    logic [LVP_TAG_W-1:0]     r_rd_tag;
    logic [DATA_WIDTH-1:0]    r_rd_value;
    logic [LVP_CONF_BITS-1:0] r_rd_conf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= i_wr_entry.valid;
        end
    end

    // Payload arrays carry no reset; the valid bit alone decides a hit.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]   <= i_wr_entry.tag;
            r_value[i_wr_idx] <= i_wr_entry.value;
            r_conf[i_wr_idx]  <= i_wr_entry.conf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else if (i_rd_en) begin
            r_rd_valid <= r_valid[i_rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_tag   <= r_tag[i_rd_idx];
            r_rd_value <= r_value[i_rd_idx];
            r_rd_conf  <= r_conf[i_rd_idx];
        end
    end

    always_comb begin
        o_rd_entry       = '0;
        o_rd_entry.valid = r_rd_valid;
        o_rd_entry.tag   = r_rd_tag;
        o_rd_entry.value = r_rd_value;
        o_rd_entry.conf  = r_rd_conf;
    end

endmodule

// File: rtl/load_value_predictor.sv
// Last-value load predictor: speculates on D-cache misses, verifies, trains confidence.
// Optional LVP_STATS_EN adds stat_pred/stat_hit/stat_miss event counters.
//
//   state   | meaning
//   IDLE    | waiting for vp_en
//   LOOKUP  | table read in flight for last_pc
//   SPEC    | prediction issued, waiting for real data to verify
//   TRAIN   | no prediction, waiting for real data to update the entry
//   RECOVER | mispredict signalled, waiting for recovery_done
module load_value_predictor
    import load_value_predictor_pkg::*;
#(
    parameter int INDEX_BITS  = LVP_INDEX_BITS,
    parameter int CONF_BITS   = LVP_CONF_BITS,
    parameter int CONF_THRESH = LVP_CONF_THRESH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    load_value_predictor_if.slave  bus
`ifdef LVP_STATS_EN
    ,
    output logic [31:0]            stat_pred,
    output logic [31:0]            stat_hit,
    output logic [31:0]            stat_miss
`endif
);

    localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
    localparam logic [CONF_BITS-1:0] CONF_ONE = CONF_BITS'(1);

    lvp_state_e            r_state;
    lvp_state_e            w_next;
    logic [DATA_WIDTH-1:0] r_last_pc;
    logic [DATA_WIDTH-1:0] r_pred_value;
    logic [DATA_WIDTH-1:0] r_pend_data;
    logic                  r_pending;
    logic                  r_done;
    logic                  r_recover;

    lvp_entry_t            w_rd_entry;
    lvp_entry_t            w_wr_entry;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic [INDEX_BITS-1:0] w_rd_idx;
    logic [INDEX_BITS-1:0] w_idx;
    logic [LVP_TAG_W-1:0]  w_tag;
    logic                  w_hit;
    logic                  w_spec_ok;
    logic                  w_mem_ok;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic                  w_match;
    logic [CONF_BITS-1:0]  w_conf_inc;
    logic                  w_set_done;
    logic                  w_set_recover;

    assign w_rd_idx   = bus.pc[INDEX_BITS+1:2];
    assign w_idx      = r_last_pc[INDEX_BITS+1:2];
    assign w_tag      = r_last_pc[DATA_WIDTH-1:INDEX_BITS+2];
    assign w_hit      = w_rd_entry.valid && (w_rd_entry.tag == w_tag);
    assign w_spec_ok  = w_hit && (32'(w_rd_entry.conf) >= 32'(unsigned'(CONF_THRESH)));
    // Data that arrived during LOOKUP is replayed from the pending latch.
    assign w_mem_ok   = bus.mem_valid || r_pending;
    assign w_mem_data = r_pending ? r_pend_data : bus.mem_data;
    assign w_match    = (w_mem_data == w_rd_entry.value);
    assign w_conf_inc = (w_rd_entry.conf == CONF_MAX) ? CONF_MAX : (w_rd_entry.conf + CONF_ONE);

    load_value_predictor_table #(
        .INDEX_BITS (INDEX_BITS)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_en    (w_rd_en),
        .i_rd_idx   (w_rd_idx),
        .o_rd_entry (w_rd_entry),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_idx),
        .i_wr_entry (w_wr_entry)
    );

    always_comb begin
        w_next           = r_state;
        w_rd_en          = 1'b0;
        w_wr_en          = 1'b0;
        w_set_done       = 1'b0;
        w_set_recover    = 1'b0;
        w_wr_entry       = '0;
        w_wr_entry.valid = 1'b1;
        w_wr_entry.tag   = w_tag;
        w_wr_entry.value = w_rd_entry.value;
        w_wr_entry.conf  = w_rd_entry.conf;
        case (r_state)
            IDLE: begin
                if (bus.vp_en) begin
                    w_rd_en = 1'b1;
                    w_next  = LOOKUP;
                end
            end
            LOOKUP: begin
                w_next = w_spec_ok ? SPEC : TRAIN;
            end
            SPEC: begin
                if (w_mem_ok) begin
                    w_wr_en = 1'b1;
                    if (w_match) begin
                        w_wr_entry.conf = w_conf_inc;
                        w_set_done      = 1'b1;
                        w_next          = IDLE;
                    end else begin
                        w_wr_entry.value = w_mem_data;
                        w_wr_entry.conf  = '0;
                        w_set_recover    = 1'b1;
                        w_next           = RECOVER;
                    end
                end
            end
            TRAIN: begin
                if (w_mem_ok) begin
                    w_wr_en = 1'b1;
                    w_next  = IDLE;
                    // Miss and value change both restart confidence from zero.
                    if (w_hit && w_match) begin
                        w_wr_entry.conf = w_conf_inc;
                    end else begin
                        w_wr_entry.value = w_mem_data;
                        w_wr_entry.conf  = '0;
                    end
                end
            end
            RECOVER: begin
                if (bus.recovery_done) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_pc    <= '0;
            r_pred_value <= '0;
            r_pend_data  <= '0;
            r_pending    <= 1'b0;
            r_done       <= 1'b0;
            r_recover    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_done    <= w_set_done;
            r_recover <= w_set_recover;
            r_pending <= (r_state == LOOKUP) && bus.mem_valid;
            if ((r_state == IDLE) && bus.vp_en) begin
                r_last_pc <= bus.pc;
            end
            if (r_state == LOOKUP) begin
                r_pred_value <= w_rd_entry.value;
                r_pend_data  <= bus.mem_data;
            end
        end
    end

    assign bus.pred_value = r_pred_value;
    assign bus.pred_valid = (r_state == SPEC);
    assign bus.vp_lock    = (r_state == SPEC) || (r_state == RECOVER);
    assign bus.done       = r_done;
    assign bus.recover    = r_recover;
    assign bus.last_pc    = r_last_pc;

`ifdef LVP_STATS_EN
    logic w_spec_entry;
    assign w_spec_entry = (r_state == LOOKUP) && w_spec_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pred <= '0;
            stat_hit  <= '0;
            stat_miss <= '0;
        end else begin
            if (w_spec_entry)  stat_pred <= stat_pred + 32'd1;
            if (w_set_done)    stat_hit  <= stat_hit + 32'd1;
            if (w_set_recover) stat_miss <= stat_miss + 32'd1;
        end
    end

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_spec_entry)  stats_event("VP_pred");
            if (w_set_done)    stats_event("VP_hit");
            if (w_set_recover) stats_event("VP_miss");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_load_value_predictor.sv
// Directed bench for load_value_predictor: cold train, confidence build-up, mispredict,
// aliasing, pending data, vp_en drop and mid-speculation reset.
module tb_load_value_predictor;
    import load_value_predictor_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    load_value_predictor_if bus();

`ifdef LVP_STATS_EN
    logic [31:0] stat_pred;
    logic [31:0] stat_hit;
    logic [31:0] stat_miss;
`endif

    load_value_predictor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef LVP_STATS_EN
        ,
        .stat_pred (stat_pred),
        .stat_hit  (stat_hit),
        .stat_miss (stat_miss)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pred_valid"}, 32'(bus.pred_valid), 0);
        check({tag, ".vp_lock"},    32'(bus.vp_lock),    0);
        check({tag, ".done"},       32'(bus.done),       0);
        check({tag, ".recover"},    32'(bus.recover),    0);
        check({tag, ".last_pc"},    bus.last_pc,         0);
        check({tag, ".pred_value"}, bus.pred_value,      0);
    endtask

    // One full request: vp_en, LOOKUP, SPEC/TRAIN, real data, optional recovery handshake.
    task automatic request(input string tag, input logic [31:0] a_pc, input logic [31:0] data,
                           input logic exp_spec, input logic [31:0] exp_pred);
        logic exp_ok;
        logic exp_bad;
        exp_ok  = exp_spec && (data == exp_pred);
        exp_bad = exp_spec && (data != exp_pred);
        bus.vp_en = 1'b1;
        bus.pc    = a_pc;
        tick();
        bus.vp_en = 1'b0;
        check({tag, ".last_pc"},   bus.last_pc, a_pc);
        check({tag, ".lookup_pv"}, 32'(bus.pred_valid), 0);
        tick();
        check({tag, ".pred_valid"}, 32'(bus.pred_valid), 32'(exp_spec));
        check({tag, ".vp_lock"},    32'(bus.vp_lock),    32'(exp_spec));
        if (exp_spec) check({tag, ".pred_value"}, bus.pred_value, exp_pred);
        bus.mem_valid = 1'b1;
        bus.mem_data  = data;
        tick();
        bus.mem_valid = 1'b0;
        check({tag, ".done"},        32'(bus.done),       32'(exp_ok));
        check({tag, ".recover"},     32'(bus.recover),    32'(exp_bad));
        check({tag, ".lock_after"},  32'(bus.vp_lock),    32'(exp_bad));
        check({tag, ".pv_after"},    32'(bus.pred_valid), 0);
        if (exp_bad) begin
            tick();
            check({tag, ".recover_1cyc"}, 32'(bus.recover), 0);
            check({tag, ".lock_held"},    32'(bus.vp_lock), 1);
            bus.recovery_done = 1'b1;
            tick();
            bus.recovery_done = 1'b0;
            check({tag, ".lock_released"}, 32'(bus.vp_lock), 0);
        end
        tick();
        check({tag, ".done_1cyc"}, 32'(bus.done), 0);
    endtask

    initial begin
        bus.vp_en         = 1'b0;
        bus.pc            = '0;
        bus.mem_valid     = 1'b0;
        bus.mem_data      = '0;
        bus.recovery_done = 1'b0;

        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: cold table, stray mem_valid/recovery_done in IDLE ignored
        bus.mem_valid     = 1'b1;
        bus.recovery_done = 1'b1;
        tick();
        bus.mem_valid     = 1'b0;
        bus.recovery_done = 1'b0;
        check("idle_ignore.done", 32'(bus.done), 0);
        check("idle_ignore.lock", 32'(bus.vp_lock), 0);
        request("s1_cold", 32'h400, 32'h55, 1'b0, 32'h0);

        // 2: confidence 0 -> 1 -> 2, then speculate and verify
        request("s2_train1", 32'h400, 32'h55, 1'b0, 32'h0);
        request("s2_train2", 32'h400, 32'h55, 1'b0, 32'h0);
        request("s2_spec",   32'h400, 32'h55, 1'b1, 32'h55);

        // 3: mispredict, then retrain from conf=0 with the new value
        request("s3_mispred", 32'h400, 32'h66, 1'b1, 32'h55);
`ifdef LVP_STATS_EN
        check("stats.pred", stat_pred, 2);
        check("stats.hit",  stat_hit,  1);
        check("stats.miss", stat_miss, 1);
`endif
        request("s3_retrain", 32'h400, 32'h66, 1'b0, 32'h0);

        // 4: alias at same index, different tag, replaces the entry
        request("s4_alias0", 32'h500, 32'h77, 1'b0, 32'h0);
        request("s4_alias1", 32'h500, 32'h77, 1'b0, 32'h0);
        request("s4_alias2", 32'h500, 32'h77, 1'b0, 32'h0);
        request("s4_alias3", 32'h500, 32'h77, 1'b1, 32'h77);
        request("s4_orig",   32'h400, 32'h66, 1'b0, 32'h0);
        request("s4_rt1",    32'h400, 32'h66, 1'b0, 32'h0);
        request("s4_rt2",    32'h400, 32'h66, 1'b0, 32'h0);

        // 5: data during LOOKUP is pended; vp_en during SPEC is dropped
        bus.vp_en = 1'b1;
        bus.pc    = 32'h400;
        tick();
        bus.vp_en     = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'h66;
        tick();
        bus.mem_valid = 1'b0;
        check("s5.pred_valid", 32'(bus.pred_valid), 1);
        check("s5.pred_value", bus.pred_value, 32'h66);
        check("s5.done_early", 32'(bus.done), 0);
        bus.vp_en = 1'b1;
        bus.pc    = 32'hABC;
        tick();
        bus.vp_en = 1'b0;
        check("s5.done",    32'(bus.done), 1);
        check("s5.last_pc", bus.last_pc, 32'h400);
        check("s5.lock",    32'(bus.vp_lock), 0);
        tick();
        check("s5.idle_pv", 32'(bus.pred_valid), 0);
        check("s5.idle_pc", bus.last_pc, 32'h400);

        // 6: async reset mid-SPEC aborts silently and clears the table
        bus.vp_en = 1'b1;
        bus.pc    = 32'h400;
        tick();
        bus.vp_en = 1'b0;
        tick();
        check("s6.in_spec", 32'(bus.pred_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("s6_rst");
        tick();
        check("s6.no_done",    32'(bus.done), 0);
        check("s6.no_recover", 32'(bus.recover), 0);
        rst_n = 1'b1;
        tick();
        request("s6_after", 32'h400, 32'h66, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
